// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared definitions for the bit-serial add sequencer.
//   - ST_IDLE / ST_RUN / ST_DONE : state encodings (also seen on dbg_state)
//   - state_e                    : FSM state type built on those encodings
//   - cnt_width()                : bit-counter width, clog2(width)+1
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // The extra bit keeps WIDTH=1 (clog2 = 0) at a legal one-bit counter.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// full_adder: single-bit combinational adder slice.
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder. One full_adder slice plus a registered
// carry computes a + b LSB-first over WIDTH cycles.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b)
//   out_valid/out_ready : result handshake (sum, WIDTH+1 bits, MSB = carry out)
//   busy                : high while in RUN
//   dbg_state           : current FSM state (ST_IDLE/ST_RUN/ST_DONE)
//   ovf                 : signed overflow of held result (SERIAL_ADD_OVF_EN only)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready, out_valid and busy depend only on registered state
// (in_ready is additionally forced low while rst_n is low); a source may hold
// valid high, and operands offered while in_ready=0 are dropped, not queued.
//
// Build option: define SERIAL_ADD_OVF_EN to add the ovf output.
module serial_add_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy,
  output logic [1:0]       dbg_state
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  import serial_add_pkg::*;

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     sum_q, sum_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   res_shift;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_shift = (res_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          res_sr_d = '0;
          carry_d  = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_shift;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // sum is only written here, so it stays stable through DONE.
          sum_d   = {fa_cout, res_shift};
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this final step.
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE) && rst_n;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign sum       = sum_q;
  assign dbg_state = state_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
